// File: rtl/streaming_argmax.sv
// Streaming argmax/argmin over framed multi-lane beats: one result per frame,
// registered one cycle after the closing beat and held until the consumer accepts it.
module streaming_argmax #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 16,
  parameter int IDX_WIDTH = 6,
  parameter int MODE      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*WIDTH-1:0]      in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_WIDTH-1:0]        out_index,
  output logic signed [WIDTH-1:0]     out_value,
  output logic                        out_truncated
);

  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state;
  logic [BEAT_W-1:0]       beat_cnt;
  logic signed [WIDTH-1:0] best_val;
  logic [IDX_WIDTH-1:0]    best_idx;

  // Strict comparison keeps the earlier candidate on ties.
  function automatic logic wins(input logic signed [WIDTH-1:0] cand,
                                input logic signed [WIDTH-1:0] cur);
    if (MODE == 0) return cand > cur;
    else           return cand < cur;
  endfunction

  logic signed [WIDTH-1:0] beat_val;
  logic [LANE_W-1:0]       beat_lane;

  always_comb begin
    beat_val  = $signed(in_data[WIDTH-1:0]);
    beat_lane = '0;
    for (int k = 1; k < LANES; k++) begin
      if (wins($signed(in_data[k*WIDTH +: WIDTH]), beat_val)) begin
        beat_val  = $signed(in_data[k*WIDTH +: WIDTH]);
        beat_lane = LANE_W'(k);
      end
    end
  end

  logic                    accept;
  logic                    closing;
  logic                    take;
  logic [IDX_WIDTH-1:0]    cand_idx;
  logic signed [WIDTH-1:0] new_val;
  logic [IDX_WIDTH-1:0]    new_idx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign closing  = accept && (in_last || beat_cnt == LAST_BEAT);
  assign cand_idx = IDX_WIDTH'(beat_cnt) * IDX_WIDTH'(LANES) + IDX_WIDTH'(beat_lane);
  // The opening beat of a frame never compares against the previous frame's best.
  assign take     = (state == IDLE) || wins(beat_val, best_val);
  assign new_val  = take ? beat_val : best_val;
  assign new_idx  = take ? cand_idx : best_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      best_val      <= '0;
      best_idx      <= '0;
      out_valid     <= 1'b0;
      out_index     <= '0;
      out_value     <= '0;
      out_truncated <= 1'b0;
    end else begin
      if (accept) begin
        best_val <= new_val;
        best_idx <= new_idx;
        if (closing) begin
          state    <= IDLE;
          beat_cnt <= '0;
        end else begin
          state    <= ACCUM;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (closing) begin
        out_valid     <= 1'b1;
        out_value     <= new_val;
        out_index     <= new_idx;
        out_truncated <= !in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_streaming_argmax.sv
// Bench for streaming_argmax: argmax and argmin instances share one stimulus stream
// and are compared against a frame-level reference plus directed literal results.
module tb_streaming_argmax;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int MB = 16;
  localparam int IW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [L*W-1:0]    in_data;
  logic              in_last;
  logic              out_ready;

  logic              in_ready0, out_valid0, out_trunc0;
  logic [IW-1:0]     out_index0;
  logic signed [W-1:0] out_value0;
  logic              in_ready1, out_valid1, out_trunc1;
  logic [IW-1:0]     out_index1;
  logic signed [W-1:0] out_value1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  streaming_argmax #(.WIDTH(W), .LANES(L), .MAX_BEATS(MB), .IDX_WIDTH(IW), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .out_index(out_index0), .out_value(out_value0), .out_truncated(out_trunc0));

  streaming_argmax #(.WIDTH(W), .LANES(L), .MAX_BEATS(MB), .IDX_WIDTH(IW), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .out_index(out_index1), .out_value(out_value1), .out_truncated(out_trunc1));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [L*W-1:0] pack(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Reference: collect the whole frame as a flat list; the result is the first
  // element of that list holding the extreme value.
  int  fr[$];
  bit  m_valid = 1'b0;
  bit  m_trunc = 1'b0;
  int  m_idx[2] = '{0, 0};
  int  m_val[2] = '{0, 0};

  initial begin
    bit acc, cl;
    int bi;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 1'b0;
        m_trunc = 1'b0;
        m_idx   = '{0, 0};
        m_val   = '{0, 0};
        fr.delete();
      end else begin
        acc = in_valid && (!m_valid || out_ready);
        cl  = 1'b0;
        if (acc) begin
          for (int k = 0; k < L; k++) fr.push_back(int'($signed(in_data[k*W +: W])));
          cl = in_last || (fr.size() == L * MB);
        end
        if (cl) begin
          for (int md = 0; md < 2; md++) begin
            bi = 0;
            for (int i = 1; i < fr.size(); i++)
              if (md == 0 ? (fr[i] > fr[bi]) : (fr[i] < fr[bi])) bi = i;
            m_idx[md] = bi;
            m_val[md] = fr[bi];
          end
          m_trunc = !in_last;
          m_valid = 1'b1;
          fr.delete();
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("in_ready0", int'(in_ready0), int'(!m_valid || out_ready));
      check("in_ready1", int'(in_ready1), int'(!m_valid || out_ready));
      check("out_valid0", int'(out_valid0), int'(m_valid));
      check("out_valid1", int'(out_valid1), int'(m_valid));
      if (m_valid) begin
        check("max_index", int'(out_index0), m_idx[0]);
        check("max_value", int'(out_value0), m_val[0]);
        check("max_trunc", int'(out_trunc0), int'(m_trunc));
        check("min_index", int'(out_index1), m_idx[1]);
        check("min_value", int'(out_value1), m_val[1]);
        check("min_trunc", int'(out_trunc1), int'(m_trunc));
      end
    end
  end

  task automatic beat(input logic [L*W-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #2;
  endtask

  task automatic expect_res(input string tag, input int i0, input int v0,
                            input int i1, input int v1, input int tr);
    check({tag, "_valid"}, int'(out_valid0), 1);
    check({tag, "_max_idx"}, int'(out_index0), i0);
    check({tag, "_max_val"}, int'(out_value0), v0);
    check({tag, "_min_idx"}, int'(out_index1), i1);
    check({tag, "_min_val"}, int'(out_value1), v1);
    check({tag, "_trunc"}, int'(out_trunc0), tr);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", int'(in_ready0), 1);
    check("rst_out_valid", int'(out_valid0), 0);
    check("rst_out_index", int'(out_index0), 0);
    check("rst_out_value", int'(out_value0), 0);
    check("rst_out_trunc", int'(out_trunc0), 0);
    rst_n = 1'b1;
    idle();

    // Single beat
    beat(pack(3, -7, 12, 12), 1'b1);
    expect_res("single", 2, 12, 1, -7, 0);
    idle();

    // Three-beat frame with a tie across beats
    beat(pack(1, 50, 2, 3), 1'b0);
    beat(pack(10, 20, -5, 0), 1'b0);
    beat(pack(50, 4, 4, 4), 1'b1);
    expect_res("three", 1, 50, 6, -5, 0);
    idle();

    // Lane tie inside a beat
    beat(pack(5, -3, -3, 9), 1'b1);
    expect_res("lanetie", 3, 9, 1, -3, 0);
    idle();

    // Truncated frame, then the next beat opens a fresh frame
    for (int b = 0; b < MB; b++) beat(pack(-128, -128, -128, -128), 1'b0);
    expect_res("trunc", 0, -128, 0, -128, 1);
    beat(pack(1, 2, 3, 4), 1'b1);
    expect_res("after_trunc", 3, 4, 0, 1, 0);
    idle();

    // Full-length frame closed by in_last on the final beat
    for (int b = 0; b < MB; b++) beat(pack(b*4 - 30, b*4 - 29, b*4 - 28, b*4 - 27), b == MB - 1);
    expect_res("fulllast", 63, 33, 0, -30, 0);
    idle();

    // Backpressure: result held, junk beat offered and ignored
    out_ready = 1'b0;
    beat(pack(7, -2, 30, 1), 1'b1);
    expect_res("bp", 2, 30, 1, -2, 0);
    in_valid = 1'b1; in_data = pack(100, 100, 100, 100); in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      idle();
      check("bp_in_ready", int'(in_ready0), 0);
      expect_res("bp_hold", 2, 30, 1, -2, 0);
    end
    out_ready = 1'b1;
    in_data = pack(-1, -2, -3, -4);
    idle();
    in_valid = 1'b0; in_last = 1'b0;
    expect_res("bp_swap", 0, -1, 3, -4, 0);
    idle();

    // Reset in the middle of a frame
    beat(pack(1, 1, 1, 1), 1'b0);
    beat(pack(1, 1, 1, 1), 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", int'(out_valid0), 0);
    check("mrst_index", int'(out_index0), 0);
    check("mrst_value", int'(out_value0), 0);
    check("mrst_in_ready", int'(in_ready0), 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle();
    beat(pack(0, 0, 9, 0), 1'b1);
    expect_res("post_rst", 2, 9, 0, 0, 0);
    check("post_rst_range", int'(out_index0 <= 3), 1);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
